// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the fetch stage's memory, decode-handshake, redirect and status
//   signals so the fetch unit and its neighbours connect through one port.
//
//   Signals:
//     read_addr     32  fetch -> imem    address being read (the PC)
//     instr_in      32  imem  -> fetch   word at read_addr, same cycle
//     instr_out     32  fetch -> decode  registered instruction
//     pc_out        32  fetch -> decode  address instr_out came from
//     instr_valid    1  fetch -> decode  instr_out/pc_out are live
//     instr_ready    1  decode -> fetch  decode accepts instr_out this cycle
//     branch_taken   1  exec  -> fetch   one-cycle redirect request
//     branch_target 32  exec  -> fetch   redirect destination
//     halted         1  fetch -> any     fetch stopped past end of program
//     fault          1  fetch -> any     sticky misaligned-redirect flag
//
//   Modports:
//     master  the fetch unit itself
//     slave   the surrounding memory / decode / execute side
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
   logic [31:0] read_addr;
   logic [31:0] instr_in;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halted;
   logic        fault;

   modport master (
      output read_addr, instr_out, pc_out, instr_valid, halted, fault,
      input  instr_in, instr_ready, branch_taken, branch_target
   );

   modport slave (
      input  read_addr, instr_out, pc_out, instr_valid, halted, fault,
      output instr_in, instr_ready, branch_taken, branch_target
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Program counter plus fetch output register. The PC drives the
//   (combinational) instruction memory address; the returned word is
//   captured into instr_out with a valid/ready handshake toward decode.
//   Handles branch redirects (one-bubble penalty), halting once the PC runs
//   past IMEM_LAST_ADDR, and optionally faulting on misaligned targets.
//
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     fetch_bus  instr_fetch_unit_if.master (memory, decode, redirect, status)
//
//   Parameters:
//     RESET_PC        PC loaded on reset
//     IMEM_LAST_ADDR  highest valid word address in instruction memory
//
//   Build option:
//     FETCH_ALIGN_CHECK_EN  when defined, a redirect whose target is not
//                           word aligned enters a sticky FAULT state; when
//                           undefined, the low two target bits are dropped.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter logic [31:0] IMEM_LAST_ADDR = 32'd68
) (
   input  logic                      clk,
   input  logic                      reset,
   instr_fetch_unit_if.master        fetch_bus
);

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
`else
   typedef enum logic [1:0] {RUN, HALT} state_t;
`endif

   state_t      state;
   logic [31:0] pc;
   logic [31:0] instr_q;
   logic [31:0] pc_out_q;
   logic        valid_q;
   logic        redirect;
   logic        load;

   // A redirect is honoured in every state except FAULT, which only reset clears.
`ifdef FETCH_ALIGN_CHECK_EN
   assign redirect = fetch_bus.branch_taken && (state != FAULT);
`else
   assign redirect = fetch_bus.branch_taken;
`endif

   // Capture a new word when the output slot is empty or being drained,
   // and the PC still points inside instruction memory.
   assign load = (state == RUN) && (!valid_q || fetch_bus.instr_ready) &&
                 !fetch_bus.branch_taken && (pc <= IMEM_LAST_ADDR);

   // NOTE: every register here uses non-blocking assignment so all state
   // updates see the pre-edge values of pc/valid_q/state.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: instr_out/pc_out are reset too, so a bus observer never sees
         // X before the first fetch even though instr_valid already guards them.
         state    <= RUN;
         pc       <= RESET_PC;
         instr_q  <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
      end else if (redirect) begin
         // Redirect wins over stall and load: the held word is flushed.
         valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         if (fetch_bus.branch_target[1:0] != 2'b00) begin
            state <= FAULT;           // pc deliberately left as is
         end else begin
            pc    <= fetch_bus.branch_target;
            state <= RUN;
         end
`else
         pc    <= fetch_bus.branch_target & ~32'd3;
         state <= RUN;
`endif
      end else begin
         if (load) begin
            instr_q  <= fetch_bus.instr_in;
            pc_out_q <= pc;
            valid_q  <= 1'b1;
            pc       <= pc + 32'd4;   // wraps naturally at 2^32
         end else if (valid_q && fetch_bus.instr_ready) begin
            valid_q <= 1'b0;
         end

         // Stop fetching once past the last word; a held word still drains.
         if ((state == RUN) && (pc > IMEM_LAST_ADDR)) begin
            state <= HALT;
         end
      end
   end

   assign fetch_bus.read_addr   = pc;
   assign fetch_bus.instr_out   = instr_q;
   assign fetch_bus.pc_out      = pc_out_q;
   assign fetch_bus.instr_valid = valid_q;
   assign fetch_bus.halted      = (state == HALT);
`ifdef FETCH_ALIGN_CHECK_EN
   assign fetch_bus.fault       = (state == FAULT);
`else
   assign fetch_bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. Instruction memory is modelled as
//   word(a) = 32'hC0DE_0000 ^ a. A second instance with IMEM_LAST_ADDR at the
//   top of the address space exercises PC wrap-around.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   instr_fetch_unit_if bus ();
   instr_fetch_unit_if bus2 ();

   instr_fetch_unit #(
      .RESET_PC       (32'h0000_0000),
      .IMEM_LAST_ADDR (32'd68)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .fetch_bus (bus)
   );

   instr_fetch_unit #(
      .RESET_PC       (32'h0000_0000),
      .IMEM_LAST_ADDR (32'hFFFF_FFFC)
   ) dut_wrap (
      .clk       (clk),
      .reset     (reset),
      .fetch_bus (bus2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   assign bus.instr_in  = mem_word(bus.read_addr);
   assign bus2.instr_in = mem_word(bus2.read_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset              = 1'b1;
      bus.instr_ready    = 1'b1;
      bus.branch_taken   = 1'b0;
      bus.branch_target  = '0;
      bus2.instr_ready   = 1'b1;
      bus2.branch_taken  = 1'b0;
      bus2.branch_target = '0;

      // ---- reset state ----
      tick();
      tick();
      check("rst_read_addr", bus.read_addr, 32'h0);
      check("rst_valid",     {31'b0, bus.instr_valid}, 32'h0);
      check("rst_instr_out", bus.instr_out, 32'h0);
      check("rst_pc_out",    bus.pc_out, 32'h0);
      check("rst_halted",    {31'b0, bus.halted}, 32'h0);
      check("rst_fault",     {31'b0, bus.fault}, 32'h0);

      // ---- straight-line fetch 0..68, one word per cycle ----
      reset = 1'b0;
      for (int k = 0; k <= 17; k++) begin
         tick();
         check($sformatf("seq_valid_%0d", k), {31'b0, bus.instr_valid}, 32'h1);
         check($sformatf("seq_pc_out_%0d", k), bus.pc_out, 32'(4 * k));
         check($sformatf("seq_instr_%0d", k), bus.instr_out, mem_word(32'(4 * k)));
         check($sformatf("seq_raddr_%0d", k), bus.read_addr, 32'(4 * k + 4));
      end
      check("pre_halt_halted", {31'b0, bus.halted}, 32'h0);
      tick();
      check("halt_halted",  {31'b0, bus.halted}, 32'h1);
      check("halt_valid",   {31'b0, bus.instr_valid}, 32'h0);
      check("halt_raddr",   bus.read_addr, 32'd72);
      tick();
      check("halt_hold",    {31'b0, bus.halted}, 32'h1);
      check("halt_pc_out",  bus.pc_out, 32'd68);

      // ---- redirect out of HALT to 0 ----
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'd0;
      tick();
      bus.branch_taken  = 1'b0;
      check("rd0_halted", {31'b0, bus.halted}, 32'h0);
      check("rd0_valid",  {31'b0, bus.instr_valid}, 32'h0);
      check("rd0_raddr",  bus.read_addr, 32'd0);
      tick();
      check("rd0_pc_out0", bus.pc_out, 32'd0);
      check("rd0_valid1",  {31'b0, bus.instr_valid}, 32'h1);
      tick();
      check("rd0_pc_out4", bus.pc_out, 32'd4);
      tick();
      check("rd0_pc_out8", bus.pc_out, 32'd8);

      // ---- 3-cycle stall at pc_out = 8 ----
      bus.instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stall_pc_out_%0d", k), bus.pc_out, 32'd8);
         check($sformatf("stall_instr_%0d", k), bus.instr_out, mem_word(32'd8));
         check($sformatf("stall_raddr_%0d", k), bus.read_addr, 32'd12);
         check($sformatf("stall_valid_%0d", k), {31'b0, bus.instr_valid}, 32'h1);
      end
      bus.instr_ready = 1'b1;
      tick();
      check("resume_pc_out12", bus.pc_out, 32'd12);
      check("resume_instr12",  bus.instr_out, mem_word(32'd12));
      tick();
      check("resume_pc_out16", bus.pc_out, 32'd16);

      // ---- redirect to 48 while stalled ----
      bus.instr_ready   = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'd48;
      tick();
      bus.branch_taken  = 1'b0;
      check("brst_valid", {31'b0, bus.instr_valid}, 32'h0);
      check("brst_raddr", bus.read_addr, 32'd48);
      tick();
      check("brst_valid1", {31'b0, bus.instr_valid}, 32'h1);
      check("brst_pc_out", bus.pc_out, 32'd48);
      check("brst_instr",  bus.instr_out, mem_word(32'd48));
      check("brst_raddr2", bus.read_addr, 32'd52);

      // ---- misaligned redirect to 50 ----
      bus.instr_ready   = 1'b1;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'd50;
      tick();
      bus.branch_taken  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      check("mis_fault", {31'b0, bus.fault}, 32'h1);
      check("mis_valid", {31'b0, bus.instr_valid}, 32'h0);
      check("mis_raddr", bus.read_addr, 32'd52);
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'd0;
      tick();
      bus.branch_taken  = 1'b0;
      tick();
      check("flt_fault",  {31'b0, bus.fault}, 32'h1);
      check("flt_valid",  {31'b0, bus.instr_valid}, 32'h0);
      check("flt_raddr",  bus.read_addr, 32'd52);
      check("flt_halted", {31'b0, bus.halted}, 32'h0);
`else
      check("mis_fault", {31'b0, bus.fault}, 32'h0);
      check("mis_valid", {31'b0, bus.instr_valid}, 32'h0);
      check("mis_raddr", bus.read_addr, 32'd48);
      tick();
      check("mis_pc_out", bus.pc_out, 32'd48);
      check("mis_valid1", {31'b0, bus.instr_valid}, 32'h1);
      tick();
`endif

      // ---- reset asserted together with a redirect ----
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'd100;
      reset             = 1'b1;
      tick();
      check("rr_raddr",  bus.read_addr, 32'h0);
      check("rr_valid",  {31'b0, bus.instr_valid}, 32'h0);
      check("rr_instr",  bus.instr_out, 32'h0);
      check("rr_pc_out", bus.pc_out, 32'h0);
      check("rr_halted", {31'b0, bus.halted}, 32'h0);
      check("rr_fault",  {31'b0, bus.fault}, 32'h0);
      reset            = 1'b0;
      bus.branch_taken = 1'b0;
      tick();
      check("rr_restart_pc_out", bus.pc_out, 32'h0);
      check("rr_restart_valid",  {31'b0, bus.instr_valid}, 32'h1);
      check("rr_restart_raddr",  bus.read_addr, 32'd4);

      // ---- PC wrap on the full-address-space instance ----
      bus2.branch_taken  = 1'b1;
      bus2.branch_target = 32'hFFFF_FFF8;
      tick();
      bus2.branch_taken  = 1'b0;
      check("wrap_raddr0", bus2.read_addr, 32'hFFFF_FFF8);
      tick();
      check("wrap_pc_out0", bus2.pc_out, 32'hFFFF_FFF8);
      tick();
      check("wrap_pc_out1", bus2.pc_out, 32'hFFFF_FFFC);
      check("wrap_raddr1",  bus2.read_addr, 32'h0);
      check("wrap_halted",  {31'b0, bus2.halted}, 32'h0);
      tick();
      check("wrap_pc_out2", bus2.pc_out, 32'h0);
      check("wrap_instr2",  bus2.instr_out, mem_word(32'h0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and fetch-register stage feeding the instruction memory. Holds the PC, drives the memory read address, captures the returned 32-bit word into an output register with valid/ready handshake toward decode, and handles branch redirects, end-of-program halt and misaligned-target faults. Memory read is combinational; this block supplies the only fetch-side state.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_LAST_ADDR, 32'd68: highest valid word address in instruction memory.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- read_addr  output  32  address to instruction memory; equals PC register.
- instr_in  input  32  word returned by memory for read_addr (same cycle).
- instr_out  output  32  registered instruction.
- pc_out  output  32  address instr_out was fetched from.
- instr_valid  output  1  instr_out/pc_out hold a live instruction.
- instr_ready  input  1  decode accepts instr_out this cycle.
- branch_taken  input  1  redirect request, single-cycle pulse.
- branch_target  input  32  redirect destination.
- halted  output  1  PC passed IMEM_LAST_ADDR; fetch stopped.
- fault  output  1  misaligned redirect target seen; sticky.

## Operation
- States: RUN, HALT, FAULT.
- Load condition: load = (state == RUN) && (!instr_valid || instr_ready) && !branch_taken && (pc <= IMEM_LAST_ADDR).
- On load: instr_out <= instr_in, pc_out <= pc, instr_valid <= 1, pc <= pc + 4 (mod 2^32).
- instr_ready with instr_valid and no load: instr_valid <= 0.
- Stall: instr_valid && !instr_ready holds instr_out, pc_out, pc unchanged.
- RUN, no redirect, pc > IMEM_LAST_ADDR -> HALT; no load; pending instr_valid still drains by normal handshake.
- Redirect (branch_taken, any state except FAULT): instr_valid <= 0 (flush, regardless of instr_ready), pc <= branch_target, state <= RUN. Redirect beats stall and load in the same cycle.
- Misaligned redirect (branch_target[1:0] != 0, check compiled in): state <= FAULT, instr_valid <= 0, pc unchanged.
- FAULT: no loads, redirects ignored, exit only by reset.
- halted = (state == HALT); fault = (state == FAULT).

## Timing
- Reset (edge with reset=1): pc = RESET_PC, instr_out = 0, pc_out = 0, instr_valid = 0, state = RUN, halted = 0, fault = 0. Reset overrides every other input, including mid-redirect or mid-stall.
- read_addr is combinational from pc; first fetch edge is the first edge after reset deasserts; instr_valid = 1 one cycle after reset release.
- Fetch latency: 1 cycle from read_addr to instr_out. Sustained throughput 1 instruction/cycle with instr_ready held high.
- Redirect penalty: 1 bubble; branch_target instruction valid on the second edge after the branch_taken edge counting that edge.
- HALT asserted the edge after the last valid word loads (pc becomes IMEM_LAST_ADDR+4, halted on next edge).
- PC wrap: pc = 32'hFFFF_FFFC increments to 0 (only reachable when IMEM_LAST_ADDR = 32'hFFFF_FFFC).

## Configuration
- FETCH_ALIGN_CHECK_EN defined: misaligned branch_target enters FAULT as above.
- Undefined: no FAULT state; branch_target[1:0] forced to 2'b00 on load into pc; fault tied to 0.

## Test plan
- Reset release, instr_ready=1 -> read_addr 0,4,8,...; instr_valid rises 1 cycle after reset; pc_out/instr_out track mem[0], mem[4], ...; halted=1 after pc_out=68 consumed and pc=72.
- instr_ready=0 for 3 cycles at pc_out=8 -> instr_out, pc_out=8 and read_addr=12 held; resume with no lost or duplicated word.
- branch_taken with target 48 while instr_valid && !instr_ready -> instr_valid=0 next cycle, then pc_out=48 valid; skipped word never presented.
- Run to HALT, then branch_taken target 0 -> halted=0, fetch restarts at 0.
- With FETCH_ALIGN_CHECK_EN: target 50 -> fault=1, instr_valid=0, later redirects ignored until reset; without macro: target 50 fetches from 48.
- reset asserted mid-stream with branch_taken=1 same cycle -> pc=RESET_PC, all outputs at reset values.
